// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 8-digit seven-segment scanner.
//   NDIG                 number of scanned digits
//   SEG_OFF / AN_OFF     active-low "all dark" values for a_to_g / an
//   REFRESH_DIV_DEFAULT  cycles per digit (1 ms at 100 MHz)
//   dig_idx_t            digit index type
//   disp_buf_t           one display/shadow buffer (nibbles, dp bits, blank bits)
package seg7_pkg;

    localparam int unsigned NDIG                = 8;
    localparam logic [6:0]  SEG_OFF             = 7'h7F;
    localparam logic [7:0]  AN_OFF              = 8'hFF;
    localparam int unsigned REFRESH_DIV_DEFAULT = 100000;

    typedef logic [2:0] dig_idx_t;

    typedef struct packed {
        logic [31:0] nib;
        logic [7:0]  dp;
        logic [7:0]  blank;
    } disp_buf_t;

    // Blank bits come up set so nothing lights before the first real load.
    localparam disp_buf_t BUF_RESET = '{nib: '0, dp: '0, blank: '1};

endpackage

// File: rtl/seg7_scan8_hex7seg.sv
// hex7seg: hex nibble to active-low seven-segment decoder.
//   x       in  4  nibble to display
//   a_to_g  out 7  segments, active-low, bit 6 = a ... bit 0 = g
module hex7seg (
    input  logic [3:0] x,
    output logic [6:0] a_to_g
);

    always_comb begin
        a_to_g = 7'h7F;
        case (x)
            4'h0: a_to_g = 7'b0000001;
            4'h1: a_to_g = 7'b1001111;
            4'h2: a_to_g = 7'b0010010;
            4'h3: a_to_g = 7'b0000110;
            4'h4: a_to_g = 7'b1001100;
            4'h5: a_to_g = 7'b0100100;
            4'h6: a_to_g = 7'b0100000;
            4'h7: a_to_g = 7'b0001111;
            4'h8: a_to_g = 7'b0000000;
            4'h9: a_to_g = 7'b0000100;
            4'hA: a_to_g = 7'b0001000;
            4'hB: a_to_g = 7'b1100000;
            4'hC: a_to_g = 7'b0110001;
            4'hD: a_to_g = 7'b1000010;
            4'hE: a_to_g = 7'b0110000;
            4'hF: a_to_g = 7'b0111000;
            default: a_to_g = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan8.sv
// seg7_scan8: time-multiplexed driver for an 8-digit common-anode display.
// Captured data lands in a shadow buffer and is copied to the display buffer
// only at frame edges, so a frame never mixes old and new digits.
//   REFRESH_DIV  cycles each digit stays lit (>= 2)
//   clk          system clock, rising edge
//   clr          synchronous active-high reset
//   load         one-cycle strobe capturing data/dp_in/blank into the shadow buffer
//   data         eight hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   dp_in        decimal point enables per digit
//   blank        per-digit force-dark
//   a_to_g       segments, active-low (bit 6 = a ... bit 0 = g)
//   an           digit enables, active-low, at most one low
//   dp           decimal point, active-low
//   frame        one-cycle pulse when digit 0 of a new frame first appears
// Build option: define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan8
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank,
    output logic [6:0]  a_to_g,
    output logic [7:0]  an,
    output logic        dp,
    output logic        frame
);

    localparam int unsigned CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    dig_idx_t      idx_q, idx_d;
    disp_buf_t     shadow_q, shadow_d;
    disp_buf_t     disp_q, disp_d;
    logic          swap_q, swap_d;
    logic          frame_q, frame_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tc;
    logic          frame_edge;
    logic [3:0]    nib_sel;
    logic [6:0]    seg_dec;
    logic [7:0]    lz_mask;
    logic          dim;

    // Prescaler, digit index and buffer swap.
    always_comb begin
        tc         = (cnt_q == CNT_LAST);
        frame_edge = tc && (idx_q == dig_idx_t'(NDIG - 1));
        cnt_d      = tc ? '0 : cnt_q + 1'b1;
        idx_d      = tc ? dig_idx_t'(idx_q + 1'b1) : idx_q;
        // A load on the frame edge still lands in shadow; display takes the
        // pre-load shadow contents, so the new data shows one frame later.
        disp_d     = frame_edge ? shadow_q : disp_q;
        shadow_d   = load ? disp_buf_t'{nib: data, dp: dp_in, blank: blank} : shadow_q;
        swap_d     = frame_edge;
        // Outputs lag idx by a cycle, so the pulse is delayed to coincide
        // with the first output cycle of digit 0.
        frame_d    = swap_q;
    end

`ifdef SEG7_LZ_BLANK_EN
    logic zero_above;

    // Digits above the most significant non-zero nibble go dark; digit 0 never does.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int unsigned i = NDIG - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q.nib[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end
`else
    always_comb begin
        lz_mask = '0;
    end
`endif

    assign nib_sel = disp_q.nib[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .x      (nib_sel),
        .a_to_g (seg_dec)
    );

    // Registered output stage.
    always_comb begin
        dim  = disp_q.blank[idx_q] | lz_mask[idx_q];
        an_d  = dim ? AN_OFF  : ~(8'b1 << idx_q);
        seg_d = dim ? SEG_OFF : seg_dec;
        dp_d  = dim ? 1'b1    : ~disp_q.dp[idx_q];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= BUF_RESET;
            disp_q   <= BUF_RESET;
            swap_q   <= 1'b0;
            frame_q  <= 1'b0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            swap_q   <= swap_d;
            frame_q  <= frame_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign a_to_g = seg_q;
    assign an     = an_q;
    assign dp     = dp_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan8.sv
module tb_seg7_scan8;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 8 * DIV;

    logic        clk;
    logic        clr;
    logic        load;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  blank;
    logic [6:0]  a_to_g;
    logic [7:0]  an;
    logic        dp;
    logic        frame;

    seg7_scan8 #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .clr    (clr),
        .load   (load),
        .data   (data),
        .dp_in  (dp_in),
        .blank  (blank),
        .a_to_g (a_to_g),
        .an     (an),
        .dp     (dp),
        .frame  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-slot expectation: {an, a_to_g, dp}
    typedef logic [7:0][15:0] fexp_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [7:0]  lit_plain;
        logic [7:0]  lit_lz;
    } vec_t;

    vec_t        tbl [6];
    fexp_t       sb_q [$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    bit          done   = 1'b0;

    logic [31:0] sh_data;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_lit;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01; 4'h1: return 7'h4F; 4'h2: return 7'h12; 4'h3: return 7'h06;
            4'h4: return 7'h4C; 4'h5: return 7'h24; 4'h6: return 7'h20; 4'h7: return 7'h0F;
            4'h8: return 7'h00; 4'h9: return 7'h04; 4'hA: return 7'h08; 4'hB: return 7'h60;
            4'hC: return 7'h31; 4'hD: return 7'h42; 4'hE: return 7'h30; default: return 7'h38;
        endcase
    endfunction

    function automatic fexp_t expect_frame(input logic [31:0] d, input logic [7:0] p,
                                           input logic [7:0] lit);
        fexp_t f;
        for (int k = 0; k < 8; k++) begin
            if (lit[k]) f[k] = {~(8'h01 << k), hex_seg(d[4*k +: 4]), ~p[k]};
            else        f[k] = {8'hFF, 7'h7F, 1'b1};
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        sh_data = '0;
        sh_dp   = '0;
        sh_lit  = '0;
    endtask

    // Frame that will follow the next frame edge shows the current shadow.
    task automatic push_next();
        sb_q.push_back(expect_frame(sh_data, sh_dp, sh_lit));
    endtask

    task automatic apply_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                              input logic [7:0] lit_plain, input logic [7:0] lit_lz);
        data  = d;
        dp_in = p;
        blank = b;
        load  = 1'b1;
        sh_data = d;
        sh_dp   = p;
`ifdef SEG7_LZ_BLANK_EN
        sh_lit  = lit_lz;
`else
        sh_lit  = lit_plain;
`endif
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    task automatic wait_frame();
        bit got;
        got = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL frame_timeout: no frame pulse within %0d cycles at %0t", FRAME + 8, $time);
        end
    endtask

    // Scoreboard consumer: each frame pulse pops one expected frame and checks
    // every cycle of it; a clr aborts the frame in progress.
    initial begin : frame_checker
        fexp_t f;
        forever begin
            @(negedge clk);
            if (!clr && frame === 1'b1) begin
                if (sb_q.size() == 0) begin
                    if (!done) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_underflow: frame pulse with no expectation at %0t", $time);
                    end
                end else begin
                    f = sb_q.pop_front();
                    for (int j = 0; j < FRAME; j++) begin
                        if (j > 0) @(negedge clk);
                        if (clr) break;
                        chk($sformatf("slot%0d_cyc%0d", j / DIV, j),
                            {15'd0, frame, an, a_to_g, dp},
                            {15'd0, (j == 0), f[j / DIV]});
                    end
                end
            end
        end
    end

    // Frame period monitor.
    initial begin : period_checker
        int unsigned since;
        bit          valid;
        since = 0;
        valid = 1'b0;
        forever begin
            @(negedge clk);
            since++;
            if (clr) begin
                valid = 1'b0;
                since = 0;
            end else if (frame === 1'b1) begin
                if (valid) chk("frame_period", since, FRAME);
                since = 0;
                valid = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tbl[0] = '{32'h76543210, 8'h01, 8'h00, 8'hFF, 8'hFF};
        tbl[1] = '{32'h76543210, 8'h00, 8'h0F, 8'hF0, 8'hF0};
        tbl[2] = '{32'h000000A5, 8'h00, 8'h00, 8'hFF, 8'h03};
        tbl[3] = '{32'h00000000, 8'h00, 8'h00, 8'hFF, 8'h01};
        tbl[4] = '{32'h0000F000, 8'h80, 8'h21, 8'hDE, 8'h0E};
        tbl[5] = '{32'h89ABCDEF, 8'hAA, 8'h00, 8'hFF, 8'hFF};

        clr = 1'b1; load = 1'b0; data = '0; dp_in = '0; blank = '0;
        reset_model();
        push_next();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_hold", {15'd0, frame, an, a_to_g, dp}, {15'd0, 1'b0, 8'hFF, 7'h7F, 1'b1});
        end
        clr = 1'b0;

        // Two dark frames with no load.
        wait_frame();
        push_next();
        wait_frame();

        // Table: load at a frame pulse, visible in the following frame.
        for (int i = 0; i < 6; i++) begin
            apply_load(tbl[i].data, tbl[i].dp, tbl[i].blank, tbl[i].lit_plain, tbl[i].lit_lz);
            push_next();
            wait_frame();
        end

        // Mid-frame load must not disturb the frame being shown (tbl[5]).
        cycles(10);
        apply_load(32'hFFFFFFFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
        push_next();
        wait_frame();

        // Load coincident with the frame edge: old data for one more frame.
        push_next();
        cycles(FRAME - 2);
        apply_load(tbl[0].data, tbl[0].dp, tbl[0].blank, tbl[0].lit_plain, tbl[0].lit_lz);
        wait_frame();
        push_next();
        wait_frame();

        // Mid-frame reset during digit 5 with a pending shadow load.
        apply_load(tbl[5].data, tbl[5].dp, tbl[5].blank, tbl[5].lit_plain, tbl[5].lit_lz);
        cycles(5 * DIV);
        clr = 1'b1;
        @(negedge clk);
        chk("mid_clr_out", {15'd0, frame, an, a_to_g, dp}, {15'd0, 1'b0, 8'hFF, 7'h7F, 1'b1});
        @(negedge clk);
        chk("mid_clr_hold", {15'd0, frame, an, a_to_g, dp}, {15'd0, 1'b0, 8'hFF, 7'h7F, 1'b1});
        clr = 1'b0;
        reset_model();
        push_next();
        wait_frame();
        push_next();
        wait_frame();
        apply_load(tbl[0].data, tbl[0].dp, tbl[0].blank, tbl[0].lit_plain, tbl[0].lit_lz);
        push_next();
        wait_frame();
        done = 1'b1;
        cycles(FRAME + 2);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan8.md
# seg7_scan8

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the ALU result path and accepts a 32-bit hex word from the ALU top level. It scans all eight digits with a programmable refresh divider and shows captured data tear-free by swapping buffers only at frame boundaries. It replaces the fixed single-digit `an`/`a_to_g` drive.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit; legal range ≥ 2; 1 ms/digit at 100 MHz.
- `clk` in 1: system clock; all state changes on its rising edge.
- `clr` in 1: synchronous, active-high reset.
- `load` in 1: single-cycle strobe; captures `data`, `dp_in` and `blank` into the shadow buffer.
- `data` in 32: eight hex nibbles; nibble k (`data[4k+3:4k]`) drives digit k; digit 0 is rightmost.
- `dp_in` in 8: bit k = 1 lights the decimal point of digit k.
- `blank` in 8: bit k = 1 forces digit k dark.
- `a_to_g` out 7: segments, active-low; bit 6 = a … bit 0 = g.
- `an` out 8: digit enables, active-low, at most one low.
- `dp` out 1: decimal point, active-low.
- `frame` out 1: one-cycle pulse marking the start of each frame.

## Operation
- The prescaler `cnt` counts from 0 to REFRESH_DIV−1. On the terminal count, `cnt` goes to 0 and the digit index `idx` advances mod 8.
- Frame edge: the terminal count with `idx`==7. On that edge:
  - `idx` goes to 0.
  - The display buffer is loaded from the shadow buffer (nibbles, dp bits, blank bits).
  - `frame` is set for one cycle.
- Load: `load`=1 writes `data`/`dp_in`/`blank` into the shadow buffer on that edge. The shadow buffer is not visible until the next frame edge.
- Load on the same edge as a frame edge:
  - The display buffer takes the pre-load shadow contents.
  - The new data appears one frame later.
- Loads during a frame never alter the digits of that frame, so there is no tearing.
- Output stage is registered from `idx` and the display buffer:
  - Digit lit: `an` = ~(1<<idx), `a_to_g` = hex7seg(nibble[idx]), `dp` = ~dp_bit[idx].
  - Digit blanked: `an` = 8'hFF, `a_to_g` = 7'h7F, `dp` = 1.
- Reset values:
  - `cnt`=0, `idx`=0.
  - Shadow and display nibbles and dp bits = 0.
  - Shadow and display blank bits = 8'hFF, so the display stays dark until the first load followed by a frame edge.
  - Outputs: `an`=8'hFF, `a_to_g`=7'h7F, `dp`=1, `frame`=0.
- `clr` asserted mid-frame or mid-load: reset values apply on that edge. Any pending shadow data is discarded.

## Timing
- Each digit is lit for exactly REFRESH_DIV cycles. The frame period is 8×REFRESH_DIV cycles.
- Output latency: `an`/`a_to_g`/`dp` lag `idx` by one cycle.
- `frame` is high in the same cycle the new digit-0 values first appear on the outputs.
- Load-to-visible latency: from the `load` edge to the next frame edge, plus one cycle. Worst case is 8×REFRESH_DIV+1 cycles.
- With `clr` high, all outputs hold reset values. The first scan edge is REFRESH_DIV cycles after `clr` falls.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digits above the most significant non-zero nibble of the display buffer are also blanked; they are OR-ed with `blank`.
  - Digit 0 is never auto-blanked.
  - The mask is computed from the display buffer, so it only changes at frame edges.
- Macro undefined: only `blank` controls darkening, and all zero nibbles display as "0".

## Structure
- Package `seg7_pkg` holds:
  - Constants `NDIG`=8, `SEG_OFF`=7'h7F, `AN_OFF`=8'hFF.
  - The default `REFRESH_DIV`.
  - A 3-bit digit-index type.
- One sub-module: the existing `hex7seg` nibble decoder, instantiated once on the `idx`-selected nibble.
- Prescaler, index counter, buffers and output registers live in `seg7_scan8`.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold `clr` 3 cycles, then run 2 frames with no `load` → `an`=8'hFF, `a_to_g`=7'h7F, `dp`=1 throughout; `frame` pulses every 32 cycles.
- Basic scan: `load` with `data`=32'h76543210, `dp_in`=8'h01, `blank`=0.
  - After the next `frame` pulse, `an` steps FE, FD, FB … 7F, 4 cycles each.
  - Digit 0 shows `a_to_g`=7'b0000001; digit 7 shows 7'b0001111.
  - `dp`=0 only while `an`=8'hFE.
- Tear-free update:
  - Mid-frame `load` of 32'hFFFFFFFF → current frame finishes with the old digits.
  - A `load` coincident with the frame edge → still shows the old data for that frame; new data appears one frame later.
- Blanking: `blank`=8'h0F → `an`=8'hFF during slots 0–3; normal scan during slots 4–7.
- Leading zeros:
  - With `SEG7_LZ_BLANK_EN`: `data`=32'h000000A5 lights only digits 0–1; `data`=0 lights only digit 0 showing "0".
  - Without the macro: all 8 digits are lit.
- Mid-frame reset: assert `clr` during digit 5 → reset outputs on the next cycle; display dark until a new `load` plus frame edge.
